hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Control-side counterpart of the decode/execute pipeline register in the 5-stage RV32I core.
- Produces the FlushE, FlushD, StallF and StallD signals the pipeline registers consume.
- Produces the operand forwarding selects for the execute stage.
- Keeps its own shadow copy of the M/W-stage destination registers, and runs a memory-wait FSM that freezes the pipeline on data-memory latency, with a timeout watchdog.

Parameters:
- REG_ADDR_W, 5, register index width.
- MAX_WAIT, 255, maximum MEM_WAIT cycles before timeout; counter width is $clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- Rs1D, Rs2D  in  REG_ADDR_W  decode-stage source registers.
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  execute-stage source/destination registers.
- RegWriteE  in  1  execute-stage instruction writes rd.
- MemReadE  in  1  execute-stage instruction is a load.
- PCSrcE  in  1  branch/jump taken in execute.
- MemAccessM  in  1  memory-stage load/store in progress.
- MemReadyM  in  1  data memory completes this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE  out  1  bubble the IF/ID and ID/EX registers.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = W result, 10 = M ALU result.
- TimeoutErr  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - RdM/RdW/RegWriteM/RegWriteW shadows = 0, state=RUN, cnt=0, TimeoutErr=0.
  - While rst_n=0, all stall/flush outputs are forced 0 and ForwardAE/BE=00.
- Shadow pipeline, on each posedge where memStall=0 and state!=ERR:
  - RdM<=RdE, RegWriteM<=RegWriteE, RdW<=RdM, RegWriteW<=RegWriteM.
  - Otherwise the shadows hold.
- Forwarding (combinational from shadows), ForwardAE:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - ForwardBE is identical using Rs2E. M beats W. x0 is never forwarded.
- Load-use: lwStall = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall:
  - (state==RUN && MemAccessM && !MemReadyM), or
  - (state==MEM_WAIT && !MemReadyM), or
  - state==ERR.
- Output priority:
  - If memStall: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0. The frozen PCSrcE and lwStall are re-evaluated once released.
  - Else: StallF=StallD=lwStall, StallE=StallM=0, FlushE=lwStall|PCSrcE, FlushD=PCSrcE.
  - If lwStall and PCSrcE coincide: FlushD=1, FlushE=1, StallF=StallD=1.
- FSM, states RUN, MEM_WAIT, ERR:
  - RUN -> MEM_WAIT when MemAccessM && !MemReadyM; cnt<=1.
  - MEM_WAIT -> RUN when MemReadyM; cnt<=0. Stalls drop in that same cycle.
  - MEM_WAIT -> ERR when !MemReadyM && cnt==MAX_WAIT; otherwise cnt<=cnt+1.
  - ERR is terminal until reset: TimeoutErr=1 and all stalls held.
- Boundaries:
  - MemReadyM in the first access cycle causes zero stall.
  - cnt never wraps (saturates into ERR).
  - Reset mid-MEM_WAIT returns to RUN immediately, asynchronously.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs StallCycles[31:0] and FlushCount[31:0], both reset to 0:
  - StallCycles increments every cycle StallF=1.
  - FlushCount increments every cycle FlushE=1.
  - Both wrap at 2^32.
- When undefined, neither the ports nor the counter logic exist.

Decomposition:
- Package hazard_pkg holds:
  - typedef enum logic[1:0] fwd_sel_t {FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10};
  - typedef enum hz_state_t {RUN, MEM_WAIT, ERR};
- Sub-module hazard_shadow holds the M/W shadow registers, the enable, and the async reset; it is instantiated once.

Test Plan:
- MemReadE=1, RdE=5, Rs1D=5, no mem access -> StallF=StallD=FlushE=1, FlushD=0 that cycle; next cycle (MemReadE=0) all 0.
- RegWriteE=1 RdE=3 at cycle n, RegWriteE=1 RdE=3 at n+1, Rs1E=3 at n+2 -> ForwardAE=10. Repeat with RdE=0 -> ForwardAE=00.
- PCSrcE=1 with lwStall=0 -> FlushD=FlushE=1, StallF=0.
- MemAccessM=1, MemReadyM=0 for 3 cycles, then 1:
  - all four stalls =1 for 3 cycles, then 0 on the ready cycle;
  - a PCSrcE=1 applied during the wait gives FlushD=0;
  - ForwardAE stays stable through the wait.
- MAX_WAIT=4, MemReadyM held 0 -> TimeoutErr=1 from the 6th stalled cycle onward; stalls remain 1 even after MemReadyM=1.
- rst_n pulsed low while in MEM_WAIT with cnt=2 -> outputs 0 immediately; after release state=RUN, TimeoutErr=0, ForwardAE/BE=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding selects, memory-wait FSM states
// and the forwarding priority function.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } hz_state_t;

  // M-stage result is younger than W, so it wins when both match.
  function automatic fwd_sel_t fwdSel(input logic hitM, input logic hitW);
    if (hitM)      return FWD_MEM;
    else if (hitW) return FWD_WB;
    else           return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_shadow.sv
// Shadow copy of the M/W-stage destination registers; advances with the
// pipeline and holds while the pipeline is frozen.
module hazard_shadow #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  RegWriteE,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic                  RegWriteM,
  output logic                  RegWriteW
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RdM       <= '0;
      RdW       <= '0;
      RegWriteM <= 1'b0;
      RegWriteW <= 1'b0;
    end else if (en) begin
      RdM       <= RdE;
      RegWriteM <= RegWriteE;
      RdW       <= RdM;
      RegWriteW <= RegWriteM;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage RV32I core: stall/flush, forwarding and memory-wait
// FSM with timeout. Optional perf counters behind HAZARD_PERF_CNT_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  RegWriteE,
  input  logic                  MemReadE,
  input  logic                  PCSrcE,
  input  logic                  MemAccessM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  TimeoutErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           StallCycles,
  output logic [31:0]           FlushCount
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  hz_state_t             state, stateNext;
  logic [CNT_W-1:0]      cnt, cntNext;
  logic [REG_ADDR_W-1:0] RdM, RdW;
  logic                  RegWriteM, RegWriteW;
  logic                  memStall, lwStall;

  assign memStall = (state == RUN && MemAccessM && !MemReadyM) ||
                    (state == MEM_WAIT && !MemReadyM) ||
                    (state == ERR);

  assign lwStall = MemReadE && (RdE != '0) && (RdE == Rs1D || RdE == Rs2D);

  assign TimeoutErr = (state == ERR);

  hazard_shadow #(.REG_ADDR_W(REG_ADDR_W)) uShadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (!memStall),
    .RdE       (RdE),
    .RegWriteE (RegWriteE),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // cnt holds the number of MEM_WAIT cycles already spent; it saturates into ERR.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      RUN: if (MemAccessM && !MemReadyM) begin
        stateNext = MEM_WAIT;
        cntNext   = CNT_W'(1);
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          stateNext = RUN;
          cntNext   = '0;
        end else if (cnt == CNT_W'(MAX_WAIT)) begin
          stateNext = ERR;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      ERR: ;
      default: begin
        stateNext = RUN;
        cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    if (rst_n) begin
      ForwardAE = fwdSel(RegWriteM && RdM != '0 && RdM == Rs1E,
                         RegWriteW && RdW != '0 && RdW == Rs1E);
      ForwardBE = fwdSel(RegWriteM && RdM != '0 && RdM == Rs2E,
                         RegWriteW && RdW != '0 && RdW == Rs2E);
      // A frozen pipeline must not flush: the held branch/load resolves after release.
      if (memStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else begin
        StallF = lwStall;
        StallD = lwStall;
        FlushE = lwStall | PCSrcE;
        FlushD = PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF) StallCycles <= StallCycles + 32'd1;
      if (FlushE) FlushCount  <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit (MAX_WAIT=4): load-use, forwarding,
// branch flush, memory wait, timeout and asynchronous reset.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic       RegWriteE, MemReadE, PCSrcE, MemAccessM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, TimeoutErr;
  logic [1:0] ForwardAE, ForwardBE;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(5), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .TimeoutErr(TimeoutErr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, checks follow a settle delay.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
    RegWriteE = 0; MemReadE = 0; PCSrcE = 0; MemAccessM = 0; MemReadyM = 0;
  endtask

  initial begin
    clearIn();
    rst_n = 1'b0;
    // hazard-provoking inputs during reset must be masked
    #2;
    MemAccessM = 1; PCSrcE = 1; MemReadE = 1; RdE = 5; Rs1D = 5;
    #1;
    chk("rst_stallF", StallF, 0);
    chk("rst_stallM", StallM, 0);
    chk("rst_flushE", FlushE, 0);
    chk("rst_flushD", FlushD, 0);
    chk("rst_fwdA", ForwardAE, 0);
    chk("rst_timeout", TimeoutErr, 0);
    clearIn();
    #4 rst_n = 1'b1;
    tick();

    // load-use
    MemReadE = 1; RdE = 5; Rs1D = 5;
    #1;
    chk("lw_stallF", StallF, 1);
    chk("lw_stallD", StallD, 1);
    chk("lw_flushE", FlushE, 1);
    chk("lw_flushD", FlushD, 0);
    chk("lw_stallE", StallE, 0);
    tick();
    MemReadE = 0;
    #1;
    chk("lw_clr_stallF", StallF, 0);
    chk("lw_clr_flushE", FlushE, 0);

    // forwarding: two writers of x3, M beats W, then W only, then none
    clearIn();
    RegWriteE = 1; RdE = 3;
    tick();
    tick();
    RegWriteE = 0; RdE = 0; Rs1E = 3; Rs2E = 3;
    #1;
    chk("fwd_A_mem", ForwardAE, 2'b10);
    chk("fwd_B_mem", ForwardBE, 2'b10);
    tick();
    #1;
    chk("fwd_A_wb", ForwardAE, 2'b01);
    tick();
    #1;
    chk("fwd_A_none", ForwardAE, 2'b00);
    RegWriteE = 1; RdE = 0;
    tick();
    tick();
    Rs1E = 0; Rs2E = 0; RegWriteE = 0;
    #1;
    chk("fwd_A_x0", ForwardAE, 2'b00);
    chk("fwd_B_x0", ForwardBE, 2'b00);

    // taken branch, then branch coinciding with load-use
    clearIn();
    PCSrcE = 1;
    #1;
    chk("br_flushD", FlushD, 1);
    chk("br_flushE", FlushE, 1);
    chk("br_stallF", StallF, 0);
    MemReadE = 1; RdE = 5; Rs2D = 5;
    #1;
    chk("brlw_flushD", FlushD, 1);
    chk("brlw_flushE", FlushE, 1);
    chk("brlw_stallF", StallF, 1);
    chk("brlw_stallD", StallD, 1);
    clearIn();
    tick();

    // memory wait of 3 cycles with x7 live in M
    RegWriteE = 1; RdE = 7;
    tick();
    RegWriteE = 0; RdE = 0; Rs1E = 7;
    MemAccessM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      PCSrcE = (i == 1);
      #1;
      chk($sformatf("mw%0d_stallF", i), StallF, 1);
      chk($sformatf("mw%0d_stallM", i), StallM, 1);
      chk($sformatf("mw%0d_flushD", i), FlushD, 0);
      chk($sformatf("mw%0d_fwdA", i), ForwardAE, 2'b10);
      tick();
    end
    PCSrcE = 0; MemReadyM = 1;
    #1;
    chk("mw_rdy_stallF", StallF, 0);
    chk("mw_rdy_stallE", StallE, 0);
    chk("mw_rdy_fwdA", ForwardAE, 2'b10);
    tick();

    // ready in the first access cycle: no stall
    MemAccessM = 1; MemReadyM = 1;
    #1;
    chk("mw0_stallM", StallM, 0);
    chk("mw0_stallF", StallF, 0);
    tick();

    // timeout: 5 stalled cycles without error, error from the 6th on
    clearIn();
    MemAccessM = 1; MemReadyM = 0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("to%0d_stallM", i), StallM, 1);
      chk($sformatf("to%0d_err", i), TimeoutErr, 0);
      tick();
    end
    #1;
    chk("to6_err", TimeoutErr, 1);
    chk("to6_stallM", StallM, 1);
    MemReadyM = 1; MemAccessM = 0; PCSrcE = 1;
    tick();
    #1;
    chk("to_sticky_err", TimeoutErr, 1);
    chk("to_sticky_stallF", StallF, 1);
    chk("to_sticky_flushD", FlushD, 0);

    // reset clears ERR
    clearIn();
    rst_n = 0;
    #2;
    rst_n = 1;
    #1;
    chk("rst_err_clr", TimeoutErr, 0);
    chk("rst_err_stallM", StallM, 0);
    tick();

    // reset in MEM_WAIT with cnt=2
    MemAccessM = 1; MemReadyM = 0;
    tick();
    tick();
    #1;
    chk("mwr_stallM_pre", StallM, 1);
    #1;
    rst_n = 0;
    #1;
    chk("mwr_stallF_rst", StallF, 0);
    chk("mwr_stallM_rst", StallM, 0);
    MemAccessM = 0;
    #2;
    rst_n = 1;
    tick();
    #1;
    chk("mwr_stallM_post", StallM, 0);
    chk("mwr_err_post", TimeoutErr, 0);
    chk("mwr_fwdA_post", ForwardAE, 2'b00);
    chk("mwr_fwdB_post", ForwardBE, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
